// File: rtl/fir_deconv_inverse_if.sv
// Stream bundle for the FIR deconvolution block:
// filtered words in, recovered samples out.
interface fir_deconv_inverse_if #(
  parameter int Sample_size  = 6,
  parameter int word_size_in = 14
);
  logic [word_size_in-1:0] FIR_in;
  logic                    in_valid;
  logic                    in_ready;
  logic [Sample_size-1:0]  Sample_out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_err;
  logic                    error_sticky;

  modport slave (
    input  FIR_in, in_valid, out_ready,
    output in_ready, Sample_out, out_valid,
    output out_err, error_sticky
  );

  modport master (
    output FIR_in, in_valid, out_ready,
    input  in_ready, Sample_out, out_valid,
    input  out_err, error_sticky
  );
endinterface

// File: rtl/fir_deconv_inverse.sv
// Inverse of the 5-tap FIR: recovers x[n] from y[n]
// with a sequential MAC and a restoring divider.
module fir_deconv_inverse #(
  parameter int FIR_order    = 4,
  parameter int Sample_size  = 6,
  parameter int weight_size  = 5,
  parameter int word_size_in = 14,
  parameter logic [weight_size-1:0] b0 = 5'd3,
  parameter logic [weight_size-1:0] b1 = 5'd7,
  parameter logic [weight_size-1:0] b2 = 5'd20,
  parameter logic [weight_size-1:0] b3 = 5'd7,
  parameter logic [weight_size-1:0] b4 = 5'd3
) (
  input  logic                clock,
  input  logic                reset,
  fir_deconv_inverse_if.slave bus
);

  localparam int RW = word_size_in + 2;
  localparam int PW = Sample_size + weight_size;
  localparam int TW = $clog2(FIR_order);
  localparam int CW = $clog2(word_size_in + 1);

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    CHK,
    DIV,
    OUT
  } state_t;

  state_t                  state_q, state_d;
  logic [Sample_size-1:0]  hist_q [FIR_order];
  logic [Sample_size-1:0]  hist_d [FIR_order];
  logic [TW-1:0]           tap_q, tap_d;
  logic signed [RW-1:0]    residual_q, residual_d;
  logic [weight_size-1:0]  rem_q, rem_d;
  logic [word_size_in-1:0] quo_q, quo_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [Sample_size-1:0]  sample_q, sample_d;
  logic                    err_q, err_d;
  logic                    sticky_q, sticky_d;

  logic [PW-1:0]           prod;
  logic [weight_size:0]    shifted;
  logic                    take;
  logic [weight_size-1:0]  rem_nx;
  logic [word_size_in-1:0] quo_nx;
  logic                    clamp;

  // tap k+1 coefficient (tap index is zero based)
  function automatic logic [weight_size-1:0] coef(
    input logic [TW-1:0] k
  );
    logic [weight_size-1:0] c;
    unique case (k)
      TW'(0):  c = b1;
      TW'(1):  c = b2;
      TW'(2):  c = b3;
      default: c = b4;
    endcase
    return c;
  endfunction

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == OUT);
  assign bus.Sample_out   = sample_q;
  assign bus.out_err      = err_q;
  assign bus.error_sticky = sticky_q;

  // datapath helpers: one MAC product, one divider step
  always_comb begin
    prod    = PW'(coef(tap_q)) * PW'(hist_q[tap_q]);
    shifted = {rem_q, quo_q[word_size_in-1]};
    take    = (shifted >= {1'b0, b0});
    rem_nx  = take ? weight_size'(shifted - {1'b0, b0})
                   : shifted[weight_size-1:0];
    quo_nx  = {quo_q[word_size_in-2:0], take};
    clamp   = |quo_nx[word_size_in-1:Sample_size];
  end

  // next-state and datapath control
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    tap_d      = tap_q;
    residual_d = residual_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    sample_d   = sample_q;
    err_d      = err_q;
    sticky_d   = sticky_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          residual_d = $signed(RW'(bus.FIR_in));
          tap_d      = '0;
          state_d    = MAC;
        end
      end
      MAC: begin
        residual_d = residual_q - $signed(RW'(prod));
        if (tap_q == TW'(FIR_order - 1)) begin
          state_d = CHK;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      CHK: begin
        if (residual_q[RW-1]) begin
          sample_d = '0;
          err_d    = 1'b1;
          state_d  = OUT;
        end else begin
          rem_d   = '0;
          quo_d   = residual_q[word_size_in-1:0];
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(word_size_in - 1)) begin
          sample_d = clamp ? '1 : quo_nx[Sample_size-1:0];
          err_d    = clamp | (rem_nx != '0);
          state_d  = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          hist_d[0] = sample_q;
          for (int k = 1; k < FIR_order; k++) begin
            hist_d[k] = hist_q[k-1];
          end
          sticky_d = sticky_q | err_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      for (int k = 0; k < FIR_order; k++) begin
        hist_q[k] <= '0;
      end
      tap_q      <= '0;
      residual_q <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      sample_q   <= '0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      tap_q      <= tap_d;
      residual_q <= residual_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      sample_q   <= sample_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
    end
  end

endmodule

// File: doc/fir_deconv_inverse.md
Name: fir_deconv_inverse

Overview:
- Inverse (deconvolution) block for the team's 5-tap FIR (coefficients 3,7,20,7,3).
- Takes the FIR output stream y[n] and recovers the original samples x[n] by recursion: x[n] = (y[n] - sum_{k=1..4} b_k*x[n-k]) / b0.
- Sits at the receive end of the filtered-sample link. Used for loopback checking of the FIR datapath.
- Multi-cycle: a sequential MAC and a restoring divider, with a valid/ready handshake on both sides.

Parameters:
- FIR_order, 4, number of delayed taps (history depth).
- Sample_size, 6, width of the recovered sample (max 63).
- weight_size, 5, coefficient width.
- word_size_in, 14, width of the FIR output word y[n] (2*Sample_size+2).
- b0, 5'd3, current-sample coefficient (divisor; must be nonzero).
- b1, 5'd7, tap-1 coefficient.
- b2, 5'd20, tap-2 coefficient.
- b3, 5'd7, tap-3 coefficient.
- b4, 5'd3, tap-4 coefficient.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- FIR_in  input  word_size_in  filtered sample y[n], unsigned.
- in_valid  input  1  FIR_in valid.
- in_ready  output  1  block can accept FIR_in.
- Sample_out  output  Sample_size  recovered x[n].
- out_valid  output  1  Sample_out valid.
- out_ready  input  1  downstream accepts Sample_out.
- out_err  output  1  error flag for the current Sample_out (inexact or clamped).
- error_sticky  output  1  OR of all out_err since reset.

Behaviour:
- Reset (synchronous, active-high, one clock, one reset):
  - State goes to IDLE; all history registers hist[1..4] are cleared to 0.
  - Sample_out=0, out_valid=0, out_err=0, error_sticky=0, in_ready=1.
  - Reset asserted mid-operation in any state aborts the sample; nothing is output.
- States: IDLE, MAC, CHK, DIV, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: residual (signed, word_size_in+2 bits) = FIR_in, tap counter = 1, go to MAC.
- MAC (4 cycles, one tap per cycle):
  - residual -= b_k*hist[k], for k=1..4.
  - After k=4 (edge E4), go to CHK.
- CHK (1 cycle):
  - If residual<0: quotient=0, remainder flag=1, go to OUT at E5.
  - Otherwise load the divider, go to DIV.
- DIV:
  - Restoring division of the nonnegative residual (< 2^word_size_in) by b0.
  - One quotient bit per cycle, word_size_in cycles; ends at E19, then go to OUT.
- Latency from the accepting edge: out_valid goes high after E19 (normal path) or after E5 (negative residual).
- OUT:
  - out_valid=1; in_ready=0. Sample_out and out_err stay stable until out_ready.
  - Sample_out = quotient, clamped to 2^Sample_size-1 if it is larger; 0 on the negative path.
  - out_err=1 if the remainder is nonzero, the residual was negative, or the quotient was clamped.
  - On out_valid&&out_ready: hist shifts (hist[k]<=hist[k-1], hist[1]<=Sample_out, using the clamped value), error_sticky |= out_err, out_valid drops, go to IDLE.
- in_ready=1 only in IDLE. A new input is accepted no earlier than the cycle after the output handshake (no overlap).
- in_valid while busy is ignored; the upstream must hold its data.
- Arithmetic: products are unsigned (Sample_size+weight_size); the residual is signed and never overflows for legal inputs (|sum| ≤ 40*63).

Test Plan:
- Reset, then impulse-response stream FIR_in = 3,7,20,7,3,0,0, with out_ready=1 -> Sample_out = 1,0,0,0,0,0,0; out_err=0; out_valid high 19 edges after each accept.
- Step of 10: FIR_in = 30,100,300,370,400,400 -> Sample_out = 10 each time; error_sticky=0.
- Full-scale step: FIR_in = 189,630,1890,2331,2520 -> Sample_out = 63 each time; no error.
- Out-of-range input after reset: FIR_in=200 -> Sample_out=63 (quotient 66 clamped, remainder 2), out_err=1, error_sticky=1; next input FIR_in=0 -> residual -441 -> Sample_out=0, out_err=1, out_valid after E5.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> Sample_out and out_valid stable, in_ready=0, FIR_in changes ignored; on release, exactly one output and history updated once.
- Reset asserted during DIV -> next cycle out_valid=0, in_ready=1, history 0; then FIR_in=3 -> Sample_out=1.
